// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access monitor: one reservation per master, hexokay generation and
// local completion of failing exclusive stores. Define EXCL_MON_STRICT_SIZE_EN to also match hsize.
module ahbl_excl_monitor #(
  parameter int N_MASTERS    = 2,
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int GRANULE_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_hready,
  output logic              src_hready_resp,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hexokay,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);
  localparam int         W_TAG = W_ADDR - GRANULE_LOG2;
  localparam logic [8:0] N_ID  = 9'(N_MASTERS);

  typedef enum logic [1:0] { D_IDLE, D_PASS, D_LOCAL } dphase_t;
  dphase_t state, state_nxt;

  logic [N_MASTERS-1:0] res_valid;
  logic [W_TAG-1:0]     res_addr [N_MASTERS];
`ifdef EXCL_MON_STRICT_SIZE_EN
  logic [2:0]           res_size [N_MASTERS];
  logic [2:0]           d_size;
  logic                 own_size_bad;
`endif

  logic             d_excl, d_write, d_excl_ok;
  logic [7:0]       d_master;
  logic [W_TAG-1:0] d_tag;

  logic [W_TAG-1:0]     tag;
  logic                 aphase, master_ok, excl_store, own_hit, store_ok;
  logic                 suppress, wr_down, set_en;
  logic [N_MASTERS-1:0] own_sel, addr_hit, set_slot, clr_slot;

  assign tag       = src_haddr[W_ADDR-1:GRANULE_LOG2];
  assign aphase    = src_hready && src_htrans[1];
  assign master_ok = {1'b0, src_hmaster} < N_ID;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    own_sel  = '0;
    addr_hit = '0;
    own_hit  = 1'b0;
`ifdef EXCL_MON_STRICT_SIZE_EN
    own_size_bad = 1'b0;
`endif
    for (int i = 0; i < N_MASTERS; i++) begin
      own_sel[i]  = (src_hmaster == 8'(i));
      addr_hit[i] = (res_addr[i] == tag);
      if (own_sel[i] && res_valid[i] && addr_hit[i]) begin
        own_hit = 1'b1;
`ifdef EXCL_MON_STRICT_SIZE_EN
        own_size_bad = (res_size[i] != src_hsize);
`endif
      end
    end
  end

  assign excl_store = src_hexcl && src_hwrite;
`ifdef EXCL_MON_STRICT_SIZE_EN
  assign store_ok   = excl_store && own_hit && !own_size_bad;
`else
  assign store_ok   = excl_store && own_hit;
`endif
  assign suppress   = aphase && excl_store && !store_ok;
  assign wr_down    = aphase && src_hwrite && !suppress;
  assign set_en     = (state == D_PASS) && dst_hready_resp && !dst_hresp
                      && d_excl && !d_write && d_excl_ok;

  always_comb begin
    set_slot = '0;
    clr_slot = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      set_slot[i] = set_en && (d_master == 8'(i));
      // A reservation landing this cycle is judged on its new tag, so a same-granule write still wins.
      clr_slot[i] = (wr_down && (set_slot[i] ? (d_tag == tag) : addr_hit[i]))
                    || (aphase && store_ok && own_sel[i]);
`ifdef EXCL_MON_STRICT_SIZE_EN
      clr_slot[i] = clr_slot[i] || (aphase && excl_store && own_size_bad && own_sel[i]);
`endif
    end
  end

  always_comb begin
    state_nxt = D_IDLE;
    if (aphase) state_nxt = suppress ? D_LOCAL : D_PASS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    if (!rst_n) begin
      state     <= D_IDLE;
      d_excl    <= 1'b0;
      d_write   <= 1'b0;
      d_excl_ok <= 1'b0;
      d_master  <= '0;
      d_tag     <= '0;
`ifdef EXCL_MON_STRICT_SIZE_EN
      d_size    <= '0;
`endif
    end else if (src_hready) begin
      state <= state_nxt;
      if (aphase) begin
        d_excl    <= src_hexcl;
        d_write   <= src_hwrite;
        d_excl_ok <= (src_hexcl && !src_hwrite && master_ok) || store_ok;
        d_master  <= src_hmaster;
        d_tag     <= tag;
`ifdef EXCL_MON_STRICT_SIZE_EN
        d_size    <= src_hsize;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the table is small, so tags are reset along with the valid bits and never hold X.
    if (!rst_n) begin
      res_valid <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        res_addr[i] <= '0;
`ifdef EXCL_MON_STRICT_SIZE_EN
        res_size[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (set_slot[i]) begin
          res_valid[i] <= 1'b1;
          res_addr[i]  <= d_tag;
`ifdef EXCL_MON_STRICT_SIZE_EN
          res_size[i]  <= d_size;
`endif
        end
        if (clr_slot[i]) res_valid[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = 1'b0;
    src_hexokay     = 1'b0;
    if (state == D_PASS) begin
      src_hready_resp = dst_hready_resp;
      src_hresp       = dst_hresp;
      src_hexokay     = dst_hready_resp && !dst_hresp && d_excl && d_excl_ok;
    end
  end

  assign src_hrdata    = dst_hrdata;
  assign dst_hready    = src_hready;
  assign dst_haddr     = src_haddr;
  assign dst_hwrite    = src_hwrite;
  assign dst_htrans    = suppress ? 2'b00 : src_htrans;
  assign dst_hsize     = src_hsize;
  assign dst_hburst    = src_hburst;
  assign dst_hprot     = src_hprot;
  assign dst_hmastlock = src_hmastlock;
  assign dst_hwdata    = src_hwdata;
endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Scoreboard bench for ahbl_excl_monitor: a driver queues expected address/data-phase results,
// a monitor pops them as the DUT presents them, and a behavioural slave serves the memory side.
module tb_ahbl_excl_monitor;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        src_hready, src_hready_resp, src_hresp, src_hwrite, src_hmastlock, src_hexcl, src_hexokay;
  logic [31:0] src_haddr, src_hwdata, src_hrdata;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize, src_hburst;
  logic [3:0]  src_hprot;
  logic [7:0]  src_hmaster;
  logic        dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
  logic [31:0] dst_haddr, dst_hwdata, dst_hrdata;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize, dst_hburst;
  logic [3:0]  dst_hprot;

  always #5 clk = ~clk;
  assign src_hready = src_hready_resp;

  ahbl_excl_monitor dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans), .src_hsize(src_hsize),
    .src_hburst(src_hburst), .src_hprot(src_hprot), .src_hmastlock(src_hmastlock),
    .src_hwdata(src_hwdata), .src_hrdata(src_hrdata), .src_hexcl(src_hexcl),
    .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans), .dst_hsize(dst_hsize),
    .dst_hburst(dst_hburst), .dst_hprot(dst_hprot), .dst_hmastlock(dst_hmastlock),
    .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  typedef struct { logic [1:0] trans; string name; } exp_a_t;
  typedef struct { logic resp; logic exok; int waits; logic chk_rd; logic [31:0] rd; string name; } exp_d_t;
  exp_a_t qa[$];
  exp_d_t qd[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave memory: unwritten words read back as {16'hC0DE, addr[15:0]}.
  logic [31:0] mem [logic [29:0]];
  int   slv_wait = 0;
  logic slv_err  = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {16'hC0DE, a[15:0]};
  endfunction

  initial begin
    logic        take, tw, terr, done, dp, dw, derr, err1;
    logic [31:0] ta, da, wd;
    int          twt, cnt;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = '0;
    dp = 1'b0; dw = 1'b0; derr = 1'b0; err1 = 1'b0; cnt = 0; da = '0;
    forever begin
      @(negedge clk);
      take = dst_hready && dst_htrans[1];
      ta = dst_haddr; tw = dst_hwrite; twt = slv_wait; terr = slv_err;
      done = dst_hready_resp; wd = dst_hwdata;
      @(posedge clk); #1;
      if (!rst_n) dp = 1'b0;
      else if (dp && !done) begin
        if (cnt > 0) cnt--; else err1 = 1'b1;
      end else begin
        if (dp && dw) mem[da[31:2]] = wd;
        dp = take; da = ta; dw = tw; cnt = twt; derr = terr; err1 = 1'b0;
      end
      if (!dp) begin dst_hready_resp = 1'b1; dst_hresp = 1'b0; end
      else if (cnt > 0) begin dst_hready_resp = 1'b0; dst_hresp = 1'b0; end
      else if (derr && !err1) begin dst_hready_resp = 1'b0; dst_hresp = 1'b1; end
      else begin
        dst_hready_resp = 1'b1; dst_hresp = derr;
        dst_hrdata = dw ? 32'h0 : mem_rd(da);
      end
    end
  end

  initial begin
    logic   pend;
    int     waits;
    exp_a_t ea;
    exp_d_t ed;
    pend = 1'b0; waits = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend) begin
          if (src_hready_resp) begin
            if (qd.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_response: got hresp %b expected no transfer", src_hresp);
            end else begin
              ed = qd.pop_front();
              check({ed.name, "_hresp"}, 32'(src_hresp), 32'(ed.resp));
              check({ed.name, "_hexokay"}, 32'(src_hexokay), 32'(ed.exok));
              check({ed.name, "_waits"}, 32'(waits), 32'(ed.waits));
              if (ed.chk_rd) check({ed.name, "_hrdata"}, src_hrdata, ed.rd);
            end
            pend = 1'b0;
          end else waits++;
        end
        if (src_hready && src_htrans[1]) begin
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_aphase: got htrans %b expected none", src_htrans);
          end else begin
            ea = qa.pop_front();
            check({ea.name, "_dst_htrans"}, 32'(dst_htrans), 32'(ea.trans));
          end
          pend = 1'b1; waits = 0;
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [7:0] m, input logic [31:0] a, input logic w,
                       input logic x, input logic [2:0] sz, input logic [31:0] wd, input int wt,
                       input logic er, input logic [1:0] e_tr, input logic e_resp, input logic e_exok,
                       input int e_waits, input logic chk_rd, input logic [31:0] e_rd);
    exp_a_t ea;
    exp_d_t ed;
    int     n;
    ea.trans = e_tr; ea.name = nm;
    ed.resp = e_resp; ed.exok = e_exok; ed.waits = e_waits; ed.chk_rd = chk_rd; ed.rd = e_rd; ed.name = nm;
    qa.push_back(ea);
    qd.push_back(ed);
    src_htrans = 2'b10; src_hmaster = m; src_haddr = a; src_hwrite = w; src_hexcl = x; src_hsize = sz;
    slv_wait = wt; slv_err = er;
    n = 0;
    do begin @(negedge clk); n++; end while (!src_hready && n < 50);
    if (!src_hready) begin
      checks++; errors++;
      $display("FAIL %s_accept: got hready low for %0d cycles expected acceptance", nm, n);
    end
    @(posedge clk); #1;
    src_htrans = 2'b00; src_hexcl = 1'b0; src_hwdata = wd;
  endtask

  task automatic ld(input string nm, input logic [7:0] m, input logic [31:0] a, input logic e_exok,
                    input int wt = 0, input logic er = 1'b0);
    issue(nm, m, a, 1'b0, 1'b1, 3'd2, 32'h0, wt, er, 2'b10, er, e_exok, wt + (er ? 1 : 0), 1'b0, 32'h0);
  endtask
  task automatic st(input string nm, input logic [7:0] m, input logic [31:0] a, input logic [31:0] wd,
                    input logic pass, input logic [2:0] sz = 3'd2);
    issue(nm, m, a, 1'b1, 1'b1, sz, wd, 0, 1'b0, pass ? 2'b10 : 2'b00, 1'b0, pass, 0, 1'b0, 32'h0);
  endtask
  task automatic wr(input string nm, input logic [7:0] m, input logic [31:0] a, input logic [31:0] wd);
    issue(nm, m, a, 1'b1, 1'b0, 3'd2, wd, 0, 1'b0, 2'b10, 1'b0, 1'b0, 0, 1'b0, 32'h0);
  endtask
  task automatic rd(input string nm, input logic [7:0] m, input logic [31:0] a, input int wt,
                    input logic [31:0] e_rd);
    issue(nm, m, a, 1'b0, 1'b0, 3'd2, 32'h0, wt, 1'b0, 2'b10, 1'b0, 1'b0, wt, 1'b1, e_rd);
  endtask
  task automatic idle(input int n);
    src_htrans = 2'b00; src_hexcl = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string nm);
    @(negedge clk);
    check({nm, "_hready_resp"}, 32'(src_hready_resp), 32'h1);
    check({nm, "_hresp"}, 32'(src_hresp), 32'h0);
    check({nm, "_hexokay"}, 32'(src_hexokay), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    src_htrans = 2'b00; src_haddr = '0; src_hwrite = 1'b0; src_hsize = 3'd2; src_hburst = 3'd0;
    src_hprot = 4'b0011; src_hmastlock = 1'b0; src_hwdata = '0; src_hexcl = 1'b0; src_hmaster = '0;
    #2 rst_n = 1'b0;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Load then store in the same granule succeeds and consumes the reservation.
    ld("t1_ld", 8'd0, 32'h1000, 1'b1); idle(1);
    st("t1_st", 8'd0, 32'h1004, 32'h1234_5678, 1'b1);
    st("t1_st2", 8'd0, 32'h1000, 32'hBAD0_0001, 1'b0);
    idle(4);
    check("t1_mem_1004", mem_rd(32'h1004), 32'h1234_5678);
    check("t1_mem_1000", mem_rd(32'h1000), 32'hC0DE_1000);

    // Another master's write to the granule kills the reservation.
    ld("t2_ld", 8'd0, 32'h1000, 1'b1); idle(1);
    wr("t2_wr", 8'd1, 32'h1002, 32'h5555_AAAA);
    st("t2_st", 8'd0, 32'h1000, 32'hBAD0_0002, 1'b0);
    idle(4);
    check("t2_mem_1000", mem_rd(32'h1000), 32'h5555_AAAA);

    // Store without reservation, then a read with two wait states.
    st("t3_st", 8'd1, 32'h2000, 32'hBAD0_0003, 1'b0);
    rd("t3_rd", 8'd1, 32'h2000, 2, 32'hC0DE_2000);
    idle(4);
    check("t3_mem_2000", mem_rd(32'h2000), 32'hC0DE_2000);

    // Load data phase and same-granule write address phase in one cycle: clear wins.
    ld("t4_ld", 8'd0, 32'h3000, 1'b1);
    wr("t4_wr", 8'd1, 32'h3000, 32'h3333_0000);
    idle(1);
    st("t4_st", 8'd0, 32'h3000, 32'hBAD0_0004, 1'b0);
    idle(4);
    check("t4_mem_3000", mem_rd(32'h3000), 32'h3333_0000);

    // Exclusive load with ERROR sets nothing.
    ld("t5_ld", 8'd0, 32'h6000, 1'b0, 0, 1'b1); idle(2);
    st("t5_st", 8'd0, 32'h6000, 32'hBAD0_0005, 1'b0);
    idle(4);

    // Size mismatch between load and store.
`ifdef EXCL_MON_STRICT_SIZE_EN
    ld("t6_ld", 8'd0, 32'h4000, 1'b1); idle(1);
    st("t6_st", 8'd0, 32'h4000, 32'h4444_4444, 1'b0, 3'd0);
    idle(4);
    check("t6_mem_4000", mem_rd(32'h4000), 32'hC0DE_4000);
`else
    ld("t6_ld", 8'd0, 32'h4000, 1'b1); idle(1);
    st("t6_st", 8'd0, 32'h4000, 32'h4444_4444, 1'b1, 3'd0);
    idle(4);
    check("t6_mem_4000", mem_rd(32'h4000), 32'h4444_4444);
`endif

    // Master ID beyond the table never holds a reservation.
    ld("t7_ld", 8'd5, 32'h7000, 1'b0); idle(1);
    st("t7_st", 8'd5, 32'h7000, 32'hBAD0_0007, 1'b0);
    idle(4);

    // Plain reads leave reservations intact.
    ld("t8_ld", 8'd0, 32'h8000, 1'b1); idle(1);
    rd("t8_rd", 8'd1, 32'h8000, 0, 32'hC0DE_8000);
    st("t8_st", 8'd0, 32'h8000, 32'h8888_0000, 1'b1);
    idle(4);
    check("t8_mem_8000", mem_rd(32'h8000), 32'h8888_0000);

    // Reset drops every reservation.
    ld("t9_ld", 8'd1, 32'h5000, 1'b1); idle(3);
    rst_n = 1'b0;
    check_reset_outputs("t9_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    st("t9_st", 8'd1, 32'h5000, 32'hBAD0_0009, 1'b0);
    idle(6);

    check("drain_aphase_queue", 32'(qa.size()), 32'h0);
    check("drain_dphase_queue", 32'(qd.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
